// File: rtl/rr_index_arbiter_8.sv
// Eight-way round-robin arbiter with a registered grant index,
// a hold limit and a forced one-cycle gap between grants.
module rr_index_arbiter_8 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic       grant_valid_o,
    output logic [2:0] grant_idx_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             any_req;
    logic             owner_req;
    logic             at_limit;

    // Walk from the lowest-priority slot back to ptr so the last
    // hit, i.e. the first in round-robin order, is what remains.
    always_comb begin
        win_idx = ptr_q;
        cand    = '0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req_i[cand]) begin
                win_idx = cand;
            end
        end
    end

    assign any_req   = |req_i;
    assign owner_req = req_i[idx_q];
    assign at_limit  = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = win_idx;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_i || !owner_req || at_limit) begin
                    to_d    = !release_i && owner_req && at_limit;
                    ptr_d   = idx_q + 3'd1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign grant_valid_o = (state_q == GRANT);
    assign grant_idx_o   = idx_q;
    assign timeout_o     = to_q;

endmodule

// File: tb/tb_rr_index_arbiter_8.sv
// Bench for rr_index_arbiter_8: directed vector table, hand-written
// corner sequences, then random traffic against a reference model.
module tb_rr_index_arbiter_8;

    localparam int HOLD = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic       gv;
    logic [2:0] gi;
    logic       to;

    int checks;
    int errors;

    rr_index_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .release_i    (rel),
        .grant_valid_o(gv),
        .grant_idx_o  (gi),
        .timeout_o    (to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rel;
        logic       v;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    vec_t tbl[19];

    // Reference model: owner, cycles held, priority pointer.
    bit m_v;
    bit m_to;
    int m_idx;
    int m_ptr;
    int m_held;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic v,
                           input logic [2:0] i, input logic t);
        chk({nm, ".valid"}, {7'd0, gv}, {7'd0, v});
        chk({nm, ".idx"}, {5'd0, gi}, {5'd0, i});
        chk({nm, ".timeout"}, {7'd0, to}, {7'd0, t});
    endtask

    task automatic cyc(input logic [7:0] r, input logic rl);
        req = r;
        rel = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_v = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_held = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl);
        bit done;
        m_to = 0;
        if (m_v) begin
            if (rl || !r[m_idx] || m_held == HOLD) begin
                m_to   = !rl && r[m_idx] && (m_held == HOLD);
                m_v    = 0;
                m_ptr  = (m_idx + 1) % 8;
                m_held = 0;
            end else begin
                m_held++;
            end
        end else if (r != 8'h00) begin
            done = 0;
            for (int k = 0; k < 8; k++) begin
                if (!done && r[(m_ptr + k) % 8]) begin
                    m_idx = (m_ptr + k) % 8;
                    done  = 1;
                end
            end
            m_v    = 1;
            m_held = 1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        rel    = 1'b0;

        tbl[0]  = '{8'h01, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[1]  = '{8'h85, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{8'h85, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{8'h85, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[4]  = '{8'h85, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{8'h85, 1'b1, 1'b0, 3'd2, 1'b0};
        tbl[6]  = '{8'h85, 1'b0, 1'b1, 3'd7, 1'b0};
        tbl[7]  = '{8'h85, 1'b0, 1'b1, 3'd7, 1'b0};
        tbl[8]  = '{8'h85, 1'b1, 1'b0, 3'd7, 1'b0};
        tbl[9]  = '{8'h85, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[10] = '{8'h85, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[14] = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[15] = '{8'h41, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[16] = '{8'h41, 1'b0, 1'b1, 3'd6, 1'b0};
        tbl[17] = '{8'h41, 1'b1, 1'b0, 3'd6, 1'b0};
        tbl[18] = '{8'h41, 1'b0, 1'b1, 3'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].req, tbl[i].rel);
            chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].to);
        end

        // Hold limit: owner 4 never releases.
        cyc(8'h00, 1'b1);
        chk_all("drop", 1'b0, 3'd0, 1'b0);
        for (int k = 1; k <= HOLD; k++) begin
            cyc(8'h10, 1'b0);
            chk_all($sformatf("hold%0d", k), 1'b1, 3'd4, 1'b0);
        end
        cyc(8'h10, 1'b0);
        chk_all("timeout", 1'b0, 3'd4, 1'b1);
        cyc(8'h10, 1'b0);
        chk_all("regrant", 1'b1, 3'd4, 1'b0);

        // Release on the limit edge takes precedence over timeout.
        for (int k = 2; k <= HOLD; k++) begin
            cyc(8'h10, 1'b0);
            chk_all($sformatf("rhold%0d", k), 1'b1, 3'd4, 1'b0);
        end
        cyc(8'h10, 1'b1);
        chk_all("rel_at_limit", 1'b0, 3'd4, 1'b0);
        cyc(8'h10, 1'b0);
        chk_all("pre_rst", 1'b1, 3'd4, 1'b0);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        req   = 8'h81;
        rel   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst0", 1'b1, 3'd0, 1'b0);
        cyc(8'h81, 1'b1);
        chk_all("post_rst_gap", 1'b0, 3'd0, 1'b0);
        cyc(8'h81, 1'b0);
        chk_all("post_rst7", 1'b1, 3'd7, 1'b0);

        // Random traffic against the model.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        req = 8'h00;
        for (int ph = 0; ph < 8; ph++) begin
            int rel_pct;
            logic [7:0] r;
            rel_pct = (ph % 2 == 0) ? 0 : 12;
            r = 8'($urandom);
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(99) < 6) begin
                    r = (ph < 4) ? 8'($urandom) : 8'($urandom & $urandom);
                end
                cyc(r, ($urandom_range(99) < rel_pct));
                model_step(r, rel);
                chk_all($sformatf("rnd%0d_%0d", ph, c), m_v, 3'(m_idx), m_to);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
